// File: rtl/rob_mem_arbiter.sv
// rob_mem_arbiter: round-robin, credit-limited sharing of one memory request port among NREQ ROBs.
// Forwarded requests carry {src, ID}; responses are routed back to the owning ROB by that source tag.
module rob_mem_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned AWIDTH    = 32,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned IDWIDTH   = 4,
    parameter int unsigned MAX_OUTST = 8,
    localparam int unsigned SRCW     = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NREQ-1:0]            in_req_val,
    input  logic [NREQ*AWIDTH-1:0]     in_req_addr,
    input  logic [NREQ*IDWIDTH-1:0]    in_req_ID,
    output logic [NREQ-1:0]            in_req_ready,
    output logic                       mem_req_val,
    output logic [AWIDTH-1:0]          mem_req_addr,
    output logic [SRCW+IDWIDTH-1:0]    mem_req_ID,
    input  logic                       mem_req_ready,
    input  logic                       mem_rsp_val,
    input  logic [SRCW+IDWIDTH-1:0]    mem_rsp_ID,
    input  logic [DWIDTH-1:0]          mem_rsp_data,
    output logic [NREQ-1:0]            out_rsp_val,
    output logic [NREQ*IDWIDTH-1:0]    out_rsp_ID,
    output logic [NREQ*DWIDTH-1:0]     out_rsp_data,
    output logic                       err
);
    localparam int unsigned CNTW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TAGW = SRCW + IDWIDTH;

    logic [SRCW-1:0]    ptr;
    logic [CNTW-1:0]    cnt [NREQ];
    logic [NREQ-1:0]    elig;
    logic [SRCW-1:0]    gnt;
    logic               gnt_found;
    logic               slot_free;
    logic               accept;
    logic [AWIDTH-1:0]  gnt_addr;
    logic [IDWIDTH-1:0] gnt_id;
    logic [SRCW-1:0]    rsp_src;
    logic [IDWIDTH-1:0] rsp_id;
    logic [NREQ-1:0]    rsp_hit;

    // (base + off) mod NREQ, valid for non-power-of-two NREQ as well
    function automatic logic [SRCW-1:0] wrap_inc(input logic [SRCW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % NREQ;
        return SRCW'(sum);
    endfunction

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = in_req_val[i] && (cnt[i] < CNTW'(MAX_OUTST));
        end
    end

    // First eligible source searching upward from ptr
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && elig[wrap_inc(ptr, k)]) begin
                gnt       = wrap_inc(ptr, k);
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        gnt_id   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt == SRCW'(i)) begin
                gnt_addr = in_req_addr[i*AWIDTH +: AWIDTH];
                gnt_id   = in_req_ID[i*IDWIDTH +: IDWIDTH];
            end
        end
    end

    assign slot_free = !mem_req_val || mem_req_ready;
    assign accept    = gnt_found && slot_free && !rst_;

    always_comb begin
        in_req_ready = '0;
        if (accept) begin
            in_req_ready[gnt] = 1'b1;
        end
    end

    // A response is honoured only for an in-range source that has credit outstanding
    assign rsp_src = mem_rsp_ID[TAGW-1 -: SRCW];
    assign rsp_id  = mem_rsp_ID[IDWIDTH-1:0];

    always_comb begin
        rsp_hit = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_hit[i] = mem_rsp_val && (rsp_src == SRCW'(i)) && (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            ptr <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= wrap_inc(gnt, 1);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept && (gnt == SRCW'(i)) && !rsp_hit[i]) begin
                    cnt[i] <= cnt[i] + CNTW'(1);
                end else if (rsp_hit[i] && !(accept && (gnt == SRCW'(i)))) begin
                    cnt[i] <= cnt[i] - CNTW'(1);
                end
            end
        end
    end

    // Single-entry output slot toward memory
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            mem_req_val  <= 1'b0;
            mem_req_addr <= '0;
            mem_req_ID   <= '0;
        end else if (accept) begin
            mem_req_val  <= 1'b1;
            mem_req_addr <= gnt_addr;
            mem_req_ID   <= {gnt, gnt_id};
        end else if (mem_req_ready) begin
            mem_req_val  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            out_rsp_val  <= '0;
            out_rsp_ID   <= '0;
            out_rsp_data <= '0;
        end else begin
            out_rsp_val <= rsp_hit;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (rsp_hit[i]) begin
                    out_rsp_ID[i*IDWIDTH +: IDWIDTH] <= rsp_id;
                    out_rsp_data[i*DWIDTH +: DWIDTH] <= mem_rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            err <= 1'b0;
        end else if (mem_rsp_val && (rsp_hit == '0)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/rob_mem_arbiter.md
# rob_mem_arbiter

Shares one memory request/response port among NREQ reorder-buffer instances. Round-robin arbitration selects among requesters with per-source outstanding-request credit limits, and tags each forwarded request with its source index in the upper ID bits. Returning memory responses are demultiplexed back to the owning ROB by that tag. The block sits between the ROB `mem_req_*`/`mem_rsp_*` ports and the memory model or controller.

## Interface
- `NREQ`, 4, number of ROB requesters (≥2)
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, response data width
- `IDWIDTH`, 4, ROB-side request ID width
- `MAX_OUTST`, 8, maximum outstanding requests per source (≥1)
- `SRCW`, $clog2(NREQ), source-tag width (derived, not overridable)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_`  in  1  reset, asynchronous, active-high (1 = reset)
- `in_req_val`  in  NREQ  per-source request valid
- `in_req_addr`  in  NREQ*AWIDTH  per-source address; source i at bits [i*AWIDTH +: AWIDTH]
- `in_req_ID`  in  NREQ*IDWIDTH  per-source request ID
- `in_req_ready`  out  NREQ  per-source accept; one-hot or zero
- `mem_req_val`  out  1  request to memory valid
- `mem_req_addr`  out  AWIDTH  request address
- `mem_req_ID`  out  SRCW+IDWIDTH  `{src, ID}`
- `mem_req_ready`  in  1  memory accepts request
- `mem_rsp_val`  in  1  memory response valid (no backpressure)
- `mem_rsp_ID`  in  SRCW+IDWIDTH  `{src, ID}` of the response
- `mem_rsp_data`  in  DWIDTH  response data
- `out_rsp_val`  out  NREQ  per-source response valid
- `out_rsp_ID`  out  NREQ*IDWIDTH  per-source response ID
- `out_rsp_data`  out  NREQ*DWIDTH  per-source response data
- `err`  out  1  sticky protocol-error flag

## Operation
- Source i is eligible when `in_req_val[i]` and `cnt[i] < MAX_OUTST`.
- Round-robin pointer `ptr` (SRCW bits) sets priority: ptr, ptr+1, … mod NREQ. The first eligible source is granted.
- Output stage is a single register slot (`mem_req_*`). Slot is free when `!mem_req_val || mem_req_ready`.
- `in_req_ready[g]` = 1 only for the granted source g, and only while the slot is free. This is a combinational function of current inputs and state.
- On accept (`in_req_val[g] && in_req_ready[g]`):
  - slot loads `{addr, {g, ID}}`
  - `cnt[g]` increments
  - `ptr` ← (g+1) mod NREQ
- No accept: `ptr` holds.
- Slot holds and is stable while `mem_req_val && !mem_req_ready`. Slot clears when accepted by memory and no new request is loaded.
- Response with `mem_rsp_val` and tag s:
  - registers `out_rsp_val[s]`=1 with `out_rsp_ID[s]`=ID and `out_rsp_data[s]`=data
  - all other `out_rsp_val` bits are 0
  - `cnt[s]` decrements
- Same-cycle accept and response on the same source: `cnt` unchanged.
- Response for a source with `cnt[s]==0`, or with `s ≥ NREQ`: response is dropped, `cnt` is unchanged, and `err` is set to 1. `err` clears only on reset.
- `cnt[i]` is $clog2(MAX_OUTST+1) bits wide and never wraps. Increment is impossible at MAX_OUTST because of the eligibility rule.

## Timing
- Reset (asynchronous assert): `mem_req_val`=0, `mem_req_addr`=0, `mem_req_ID`=0, `out_rsp_val`=0, `out_rsp_ID`=0, `out_rsp_data`=0, `err`=0, `ptr`=0, all `cnt`=0. `in_req_ready`=0 while reset is asserted.
- Deassertion: first accept possible on the first rising edge after `rst_` falls.
- Request latency: accept at edge N gives `mem_req_val`=1 after edge N.
- Throughput: one request per cycle with `mem_req_ready`=1.
- Response latency: `mem_rsp_val` sampled at edge N gives `out_rsp_val[s]` high for exactly the cycle after edge N.
- Reset mid-operation: in-flight slot content and counters are discarded. Late responses after reset are handled by the `err` rule.

## Test plan
- Reset, then all four sources hold `val`=1 with IDs 1..4 and `mem_req_ready`=1 -> grants 0,1,2,3,0 on consecutive cycles; `mem_req_ID` = 0x01, 0x12, 0x23, 0x34, then source 0's next ID.
- Source 2 issues 8 requests with no responses -> `in_req_ready[2]`=0 on the 9th. One response with tag 2 -> ready returns the cycle after; `out_rsp_val[2]` pulses 1 cycle with the matching ID and data.
- `mem_req_ready`=0 for 3 cycles with the slot full -> `mem_req_*` stable, every `in_req_ready`=0. Ready rises -> next grant follows the round-robin pointer, not source 0.
- Same cycle: source 1 accepted and response for source 1 arrives with `cnt[1]`=3 -> `cnt[1]` stays 3, and `out_rsp_val[1]`=1 next cycle.
- Response with tag 3 while `cnt[3]`=0 -> no `out_rsp_val`, `err`=1 and held. Assert `rst_` asynchronously mid-burst -> all outputs 0 immediately, `err`=0.
